// File: rtl/regfile_2r1w.sv
// RV32I integer register file: 32 x DATA_W, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, optional write-through.
module regfile_2r1w #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter bit          BYPASS = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [$clog2(DEPTH)-1:0] i_rs1_addr,
    input  logic [$clog2(DEPTH)-1:0] i_rs2_addr,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    input  logic                     i_rd_wren,
    input  logic [DATA_W-1:0]        i_rd_data,
    output logic [DATA_W-1:0]        o_rs1_data,
    output logic [DATA_W-1:0]        o_rs2_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] rf [DEPTH];

    // x0 has no storage; its read value is a constant zero.
    assign rf[0] = '0;

    for (genvar r = 1; r < DEPTH; r++) begin : g_reg
        logic              we;
        logic [DATA_W-1:0] reg_d;
        logic [DATA_W-1:0] reg_q;

        assign we    = i_rd_wren && (i_rd_addr == AW'(r));
        assign reg_d = we ? i_rd_data : reg_q;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign rf[r] = reg_q;
    end

    // Forwarding is suppressed in reset so outputs read zero throughout.
    logic wr_live;
    logic rs1_hit;
    logic rs2_hit;

    assign wr_live = !i_rst && i_rd_wren && (i_rd_addr != '0);
    assign rs1_hit = BYPASS && wr_live && (i_rs1_addr == i_rd_addr);
    assign rs2_hit = BYPASS && wr_live && (i_rs2_addr == i_rd_addr);

    assign o_rs1_data = rs1_hit ? i_rd_data : rf[i_rs1_addr];
    assign o_rs2_data = rs2_hit ? i_rd_data : rf[i_rs2_addr];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w, run with and
// without write-through forwarding side by side on shared inputs.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic [31:0] rd_data;
    logic [31:0] nb_rs1;
    logic [31:0] nb_rs2;
    logic [31:0] bp_rs1;
    logic [31:0] bp_rs2;

    logic [31:0] model [32];
    int          n_checks;
    int          n_errors;

    regfile_2r1w #(.DATA_W(32), .DEPTH(32), .BYPASS(1'b0)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .i_rd_addr  (rd_addr),
        .i_rd_wren  (rd_wren),
        .i_rd_data  (rd_data),
        .o_rs1_data (nb_rs1),
        .o_rs2_data (nb_rs2)
    );

    regfile_2r1w #(.DATA_W(32), .DEPTH(32), .BYPASS(1'b1)) dut_bp (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .i_rd_addr  (rd_addr),
        .i_rd_wren  (rd_wren),
        .i_rd_data  (rd_data),
        .o_rs1_data (bp_rs1),
        .o_rs2_data (bp_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rd_addr = a;
        rd_data = d;
        rd_wren = 1'b1;
        @(posedge clk);
        #1;
        rd_wren = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            chk({tag, "_nb_rs1"}, nb_rs1, model[i]);
            chk({tag, "_nb_rs2"}, nb_rs2, model[31 - i]);
            chk({tag, "_bp_rs1"}, bp_rs1, model[i]);
            chk({tag, "_bp_rs2"}, bp_rs2, model[31 - i]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_model();
        rst      = 1'b1;
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        rd_addr  = 5'd0;
        rd_wren  = 1'b0;
        rd_data  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rs1", nb_rs1, 32'h0);
        chk("rst_rs2", bp_rs2, 32'h0);

        // Write presented on the first edge after deassertion lands.
        @(negedge clk);
        rst     = 1'b0;
        rd_addr = 5'd4;
        rd_data = 32'hCAFE0004;
        rd_wren = 1'b1;
        @(posedge clk);
        #1;
        rd_wren  = 1'b0;
        rs1_addr = 5'd4;
        #1;
        chk("first_wr", nb_rs1, 32'hCAFE0004);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A50000 | 32'(i));
        sweep("all");
        rs1_addr = 5'd7;
        rs2_addr = 5'd31;
        #1;
        chk("pair_rs1", nb_rs1, 32'hA5A50007);
        chk("pair_rs2", nb_rs2, 32'hA5A5001F);

        wr(5'd0, 32'hFFFFFFFF);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        #1;
        chk("x0_rs1", nb_rs1, 32'h0);
        chk("x0_rs2", bp_rs2, 32'h0);
        sweep("x0");

        wr(5'd9, 32'h11111111);
        @(negedge clk);
        rs1_addr = 5'd9;
        rs2_addr = 5'd9;
        rd_addr  = 5'd9;
        rd_data  = 32'h22222222;
        rd_wren  = 1'b1;
        #1;
        chk("rw_nb_rs1_pre", nb_rs1, 32'h11111111);
        chk("rw_nb_rs2_pre", nb_rs2, 32'h11111111);
        chk("rw_bp_rs1_pre", bp_rs1, 32'h22222222);
        chk("rw_bp_rs2_pre", bp_rs2, 32'h22222222);
        @(posedge clk);
        #1;
        rd_wren  = 1'b0;
        model[9] = 32'h22222222;
        #1;
        chk("rw_nb_rs1_post", nb_rs1, 32'h22222222);
        chk("rw_nb_rs2_post", nb_rs2, 32'h22222222);

        @(negedge clk);
        rd_addr  = 5'd3;
        rd_data  = 32'h00001234;
        rd_wren  = 1'b0;
        rs1_addr = 5'd3;
        @(posedge clk);
        #1;
        chk("wren_off", nb_rs1, 32'hA5A50003);

        rs1_addr = 5'd12;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            rd_addr = 5'd12;
            rd_data = 32'(k);
            rd_wren = 1'b1;
            @(posedge clk);
            #1;
            chk("b2b", nb_rs1, 32'(k));
        end
        rd_wren   = 1'b0;
        model[12] = 32'h3;
        sweep("b2b_final");

        wr(5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        #1;
        chk("x5_loaded", nb_rs1, 32'hDEADBEEF);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_nb", nb_rs1, 32'h0);
        chk("async_rst_bp", bp_rs1, 32'h0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        sweep("post_rst");

        wr(5'd3, 32'h00003333);
        @(negedge clk);
        rst      = 1'b1;
        rd_addr  = 5'd3;
        rd_data  = 32'h00001234;
        rd_wren  = 1'b1;
        rs1_addr = 5'd3;
        rs2_addr = 5'd3;
        #1;
        chk("rst_bp_gate_rs1", bp_rs1, 32'h0);
        chk("rst_bp_gate_rs2", bp_rs2, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_cancel_wr", nb_rs1, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        rd_wren = 1'b0;
        clear_model();
        sweep("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

32 x 32-bit RV32I integer register file with two asynchronous read ports and one synchronous write port. It sits directly upstream of the ALU and its shift units: rs1 and rs2 read data become the ALU operands, e.g. i_a and i_b of the logical right shifter. It also sits downstream of the writeback mux: the rd write port consumes the selected ALU, load or PC+4 result. An optional write-through bypass lets a same-cycle read of the register being written return the new value.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of architectural registers; address width is log2(DEPTH) = 5
- BYPASS, 0, 1 = write-through forwarding on both read ports; 0 = reads return the stored value only

- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  reset, asynchronous, active-high; clears every register
- i_rs1_addr  input  5  read port 1 address
- i_rs2_addr  input  5  read port 2 address
- i_rd_addr  input  5  write address
- i_rd_wren  input  1  write enable
- i_rd_data  input  DATA_W  write data
- o_rs1_data  output  DATA_W  read port 1 data
- o_rs2_data  output  DATA_W  read port 2 data

## Operation
- Storage: registers x1..x(DEPTH-1), each DATA_W flops. x0 has no storage.
- Reads: combinational, `o_rsN_data = reg[i_rsN_addr]`.
  - Address 0 always returns 0, regardless of BYPASS or write activity.
  - Both ports are independent. Equal addresses on both ports return identical data.
- Write: on a rising i_clk edge with i_rd_wren=1 and i_rd_addr != 0, `reg[i_rd_addr] <= i_rd_data`.
  - i_rd_addr == 0 with i_rd_wren=1: the write is discarded with no side effect.
  - i_rd_wren=0: all registers hold.
- Bypass (BYPASS=1): if i_rd_wren=1, i_rd_addr != 0 and i_rsN_addr == i_rd_addr, then o_rsN_data = i_rd_data combinationally in the same cycle. Applies to either or both ports simultaneously.
- No bypass (BYPASS=0): in the same-address case the port returns the old value until the edge, then the new value.
- Reset: i_rst=1 asynchronously forces every register to 0, independent of i_clk.
  - While i_rst=1, writes are ignored and both outputs read 0 for any address, including the BYPASS=1 hit case (bypass is gated by !i_rst).
  - Deassertion takes effect at the next rising edge. A write presented on the first edge after deassertion is performed.
- Width rules: no sign or zero manipulation; data is stored and returned bit-exact. Address bits are used directly; no out-of-range addresses exist for DEPTH=32.

## Timing
- Read latency: 0 cycles, a combinational path from address (and from write data when BYPASS=1) to output.
- Write latency: 1 edge. Data written at edge N is visible on a non-bypassed read after edge N.
- Reset values: all registers 0; o_rs1_data = o_rs2_data = 0 during reset.
- Reset mid-operation: asserting i_rst in the same cycle as a write cancels the write. The register is 0 after the edge, not i_rd_data.
- No handshake and no stall: one write per cycle maximum, back-to-back writes to the same address keep the last one.
- Critical path: 32:1 read mux of DATA_W bits, plus a 2:1 bypass mux when BYPASS=1. Must close at the single-cycle core clock together with the downstream ALU.

## Test plan
- Reset: pulse i_rst asynchronously mid-cycle after loading x5=0xDEADBEEF -> o_rs1_data for addr 5 drops to 0 without a clock edge; every address reads 0 after release.
- x0 protection: write 0xFFFFFFFF to addr 0, then read addr 0 on both ports -> 0x00000000. No other register changes.
- Write/read all: write reg[i] = 0xA5A50000 | i for i = 1..31, then sweep both ports -> every read matches. Simultaneous rs1=7, rs2=31 returns 0xA5A50007 / 0xA5A5001F.
- Same-cycle read-of-write: x9 = 0x11111111, then write 0x22222222 to x9 while reading x9 on both ports:
  - BYPASS=0 -> 0x11111111 before the edge, 0x22222222 after.
  - BYPASS=1 -> 0x22222222 immediately.
- Write gated by enable and reset: i_rd_wren=0 with addr 3 and data 0x1234 -> x3 unchanged. i_rst=1 with i_rd_wren=1, addr 3 -> x3 = 0 after the edge.
- Back-to-back: write x12 = 0x1, 0x2, 0x3 on consecutive edges while reading x12 -> non-bypassed reads show 0x1, 0x2, 0x3 one edge after each write; the final value is 0x3.
